mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/mux_arbiter_rr_pick.sv | 27 ++
 rtl/mux_arbiter.sv | 84 ++++++++
 tb/tb_mux_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared widths and FSM state type for the 8-way mux arbiter
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// rtl/mux_arbiter_rr_pick.sv - combinational round-robin search from a start index
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] pos;

    // Positions are SEL_W bits wide, so start+i wraps past 7 back to 0 naturally.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = start + SEL_W'(i);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin grant FSM with hold limit driving an 8:1 mux select
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] MUX_sel
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t           state, state_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic [SEL_W-1:0] last_owner, last_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0] pick_start, pick_idx;
    logic             pick_found;

    assign pick_start = last_owner + 3'd1;

    rr_pick u_pick (
        .req   (req),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // last_owner doubles as the current owner index while in GRANT.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last_owner;
        sel_nxt   = MUX_sel;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                hold_nxt  = '0;
                if (arb_en && pick_found) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = N_REQ'(1) << pick_idx;
                    sel_nxt   = pick_idx;
                    last_nxt  = pick_idx;
                    hold_nxt  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (!req[last_owner] || hold_cnt == HOLD_LIM) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            last_owner  <= 3'd7;
            MUX_sel     <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            last_owner  <= last_nxt;
            MUX_sel     <= sel_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - self-checking bench for mux_arbiter with HOLD_MAX=4
module tb_mux_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] MUX_sel;

    int checks   = 0;
    int failures = 0;

    int m_owner;
    int m_last;
    int m_sel;
    int m_cnt;
    logic [2:0] prev_sel;

    typedef struct {
        logic       r;
        logic       e;
        logic [7:0] q;
        logic [7:0] eg;
        logic [2:0] es;
    } vec_t;

    vec_t vecs[17];

    mux_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .MUX_sel     (MUX_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: owner as integer (-1 = none), search by modular scan.
    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        if (r) begin
            m_owner = -1; m_last = 7; m_sel = 0; m_cnt = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || m_cnt == HOLD) begin
                m_owner = -1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (e && q != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (m_owner < 0 && q[c]) begin
                    m_owner = c; m_last = c; m_sel = c; m_cnt = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] mg;
        rst = r; arb_en = e; req = q;
        @(posedge clk);
        model_step(r, e, q);
        #1;
        mg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        chk("model_grant", grant, mg);
        chk("model_valid", grant_valid, m_owner >= 0);
        chk("model_sel", MUX_sel, m_sel);
        chk("onehot", $countones(grant) <= 1, 1);
        chk("valid_or", grant_valid, |grant);
        if (!grant_valid && !r) chk("sel_stable", MUX_sel, prev_sel);
        prev_sel = MUX_sel;
    endtask

    task automatic cycle_exp(input string name, input logic r, input logic e, input logic [7:0] q,
                             input logic [7:0] eg, input logic [2:0] es);
        cycle(r, e, q);
        chk({name, "_grant"}, grant, eg);
        chk({name, "_valid"}, grant_valid, eg != 8'h00);
        chk({name, "_sel"}, MUX_sel, es);
    endtask

    initial begin
        rst = 1'b1; arb_en = 1'b0; req = 8'h00;
        m_owner = -1; m_last = 7; m_sel = 0; m_cnt = 0; prev_sel = 3'd0;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h81, 8'h01, 3'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h81, 8'h01, 3'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'h80, 8'h00, 3'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h80, 8'h80, 3'd7};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd7};
        vecs[6]  = '{1'b0, 1'b0, 8'h10, 8'h00, 3'd7};
        vecs[7]  = '{1'b0, 1'b0, 8'h10, 8'h00, 3'd7};
        vecs[8]  = '{1'b0, 1'b1, 8'h10, 8'h10, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 8'h10, 8'h10, 3'd4};
        vecs[10] = '{1'b0, 1'b0, 8'h10, 8'h10, 3'd4};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd4};
        vecs[12] = '{1'b0, 1'b1, 8'h20, 8'h20, 3'd5};
        vecs[13] = '{1'b0, 1'b1, 8'h20, 8'h20, 3'd5};
        vecs[14] = '{1'b1, 1'b1, 8'h20, 8'h00, 3'd0};
        vecs[15] = '{1'b0, 1'b1, 8'h21, 8'h01, 3'd0};
        vecs[16] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0};

        for (int i = 0; i < 17; i++) begin
            cycle_exp($sformatf("vec%0d", i), vecs[i].r, vecs[i].e, vecs[i].q, vecs[i].eg, vecs[i].es);
        end

        // All requesting: rotate 0..7,0 with HOLD-cycle grants and one idle gap.
        cycle(1'b1, 1'b0, 8'h00);
        for (int g = 0; g < 9; g++) begin
            for (int h = 0; h < HOLD; h++) begin
                cycle_exp("rot_hold", 1'b0, 1'b1, 8'hFF, 8'h01 << (g % 8), 3'(g % 8));
            end
            cycle_exp("rot_gap", 1'b0, 1'b1, 8'hFF, 8'h00, 3'(g % 8));
        end

        // Lone requester re-granted after expiry.
        cycle(1'b1, 1'b0, 8'h00);
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h < HOLD; h++) begin
                cycle_exp("solo_hold", 1'b0, 1'b1, 8'h08, 8'h08, 3'd3);
            end
            cycle_exp("solo_gap", 1'b0, 1'b1, 8'h08, 8'h00, 3'd3);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] q;
            q = 8'($urandom);
            if ($urandom_range(0, 3) == 0) q = 8'h01 << $urandom_range(0, 7);
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
